// File: rtl/prep_log_ingest_pkg.sv
// Shared definitions for the request-ingest stage of the replica pipeline:
// default widths, the ingest state encoding and the byte-to-word helper.
package prep_log_ingest_pkg;

  localparam int DATA_W_DEF     = 512;
  localparam int LOG_ADDR_W_DEF = 12;
  localparam int LEN_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INGEST = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } ingest_state_e;

  // Number of log words needed to hold len bytes (rounded up).
  function automatic int unsigned bytes_to_words(input int unsigned len,
                                                 input int unsigned data_w);
    int unsigned bpw;
    bpw = data_w / 8;
    return (len + bpw - 1) / bpw;
  endfunction

endpackage

// File: rtl/prep_log_ingest.sv
// Request-ingest stage: on a start pulse, latch the log slot base and request
// length, then pass payload beats straight into the log write port with
// wrapping word addresses. Length/last disagreements are flagged, with any
// excess beats drained, and a sticky done flag is held for the controller.
//
// state   | meaning
// IDLE    | waiting for the first start after reset
// INGEST  | payload beats pass through to the log write port
// DRAIN   | request ran past its length; beats discarded until last
// DONE    | request finished; done flag held until the next start
module prep_log_ingest
  import prep_log_ingest_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LOG_ADDR_W = LOG_ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_req_ingest,
  input  logic [LOG_ADDR_W-1:0] ingest_base_addr,
  input  logic [LEN_W-1:0]      ingest_req_len,
  input  logic                  manage_prep_req_val,
  input  logic [DATA_W-1:0]     manage_prep_req_data,
  input  logic                  manage_prep_req_last,
  output logic                  prep_manage_req_rdy,
  output logic                  log_wr_val,
  output logic [LOG_ADDR_W-1:0] log_wr_addr,
  output logic [DATA_W-1:0]     log_wr_data,
  input  logic                  log_wr_rdy,
  output logic                  log_write_done,
  output logic                  ingest_len_err,
  output logic                  ingest_busy
);

  ingest_state_e         r_state;
  logic [LOG_ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]      r_words;
  logic [LEN_W-1:0]      r_count;
  logic                  r_done;
  logic                  r_err;
  logic                  r_busy;

  logic                  w_start_ok;
  logic [LEN_W-1:0]      w_words;
  logic [LEN_W-1:0]      w_count_nxt;
  logic                  w_at_end;
  logic                  w_xfer;

  // Start qualification, word count of the incoming request and beat handshake.
  always_comb begin
    w_start_ok  = start_req_ingest & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    w_words     = LEN_W'(bytes_to_words(32'(ingest_req_len), DATA_W));
    w_xfer      = (r_state == ST_INGEST) & manage_prep_req_val & log_wr_rdy;
    w_count_nxt = r_count + LEN_W'(1);
    w_at_end    = (w_count_nxt == r_words);
  end

  // Ingest FSM with address/beat counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_words <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_addr  <= ingest_base_addr;
            r_words <= w_words;
            r_count <= '0;
            r_err   <= 1'b0;
            if (w_words == '0) begin
              // Nothing to consume; report completion right away.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_INGEST;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_INGEST: begin
          if (w_xfer) begin
            r_addr  <= r_addr + LOG_ADDR_W'(1);
            r_count <= w_count_nxt;
            if (w_at_end && manage_prep_req_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_at_end) begin
              r_state <= ST_DRAIN;
              r_err   <= 1'b1;
            end else if (manage_prep_req_last) begin
              // Short request: what was written stays in the log.
              r_state <= ST_DONE;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (manage_prep_req_val && manage_prep_req_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency pass-through to the log port; everything is gated by state so
  // the write port stays quiet outside INGEST.
  always_comb begin
    log_wr_val          = 1'b0;
    log_wr_addr         = '0;
    log_wr_data         = '0;
    prep_manage_req_rdy = 1'b0;
    case (r_state)
      ST_INGEST: begin
        log_wr_val          = manage_prep_req_val;
        log_wr_addr         = r_addr;
        log_wr_data         = manage_prep_req_data;
        prep_manage_req_rdy = log_wr_rdy;
      end
      ST_DRAIN: prep_manage_req_rdy = 1'b1;
      default:  prep_manage_req_rdy = 1'b0;
    endcase
  end

  assign log_write_done = r_done;
  assign ingest_len_err = r_err;
  assign ingest_busy    = r_busy;

endmodule

// File: tb/tb_prep_log_ingest.sv
// Directed bench for prep_log_ingest: hand-computed addresses, data and flags.
module tb_prep_log_ingest;

  localparam int DW = 512;
  localparam int AW = 12;
  localparam int LW = 16;

  logic          clk;
  logic          rst;
  logic          start_req_ingest;
  logic [AW-1:0] ingest_base_addr;
  logic [LW-1:0] ingest_req_len;
  logic          manage_prep_req_val;
  logic [DW-1:0] manage_prep_req_data;
  logic          manage_prep_req_last;
  logic          prep_manage_req_rdy;
  logic          log_wr_val;
  logic [AW-1:0] log_wr_addr;
  logic [DW-1:0] log_wr_data;
  logic          log_wr_rdy;
  logic          log_write_done;
  logic          ingest_len_err;
  logic          ingest_busy;

  prep_log_ingest #(.DATA_W(DW), .LOG_ADDR_W(AW), .LEN_W(LW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_req_ingest     (start_req_ingest),
    .ingest_base_addr     (ingest_base_addr),
    .ingest_req_len       (ingest_req_len),
    .manage_prep_req_val  (manage_prep_req_val),
    .manage_prep_req_data (manage_prep_req_data),
    .manage_prep_req_last (manage_prep_req_last),
    .prep_manage_req_rdy  (prep_manage_req_rdy),
    .log_wr_val           (log_wr_val),
    .log_wr_addr          (log_wr_addr),
    .log_wr_data          (log_wr_data),
    .log_wr_rdy           (log_wr_rdy),
    .log_write_done       (log_write_done),
    .ingest_len_err       (ingest_len_err),
    .ingest_busy          (ingest_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int t, input int i);
    logic [31:0] w;
    w = 32'(t * 256 + i) ^ 32'hC0DE_0000;
    return {16{w}};
  endfunction

  // Log write and drain observer.
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            n_drain = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (log_wr_val && log_wr_rdy) begin
        wa_q.push_back(log_wr_addr);
        wd_q.push_back(log_wr_data);
      end
      if (manage_prep_req_val && prep_manage_req_rdy && !log_wr_val) n_drain++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    start_req_ingest = 1'b1;
    ingest_base_addr = b;
    ingest_req_len   = l;
    tick();
    start_req_ingest = 1'b0;
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic beat(input logic [DW-1:0] d, input logic l, input string tag);
    bit ok;
    ok = 1'b0;
    manage_prep_req_val  = 1'b1;
    manage_prep_req_data = d;
    manage_prep_req_last = l;
    for (int c = 0; c < 40 && !ok; c++) begin
      #1;
      if (prep_manage_req_rdy) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    manage_prep_req_val  = 1'b0;
    manage_prep_req_last = 1'b0;
    chk({tag, "_accepted"}, DW'(ok), DW'(1));
  endtask

  int              w0;
  int              d0;
  int              k;
  bit              xf;
  logic [AW-1:0]   exp_a2[4];

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst                  = 1'b1;
    start_req_ingest     = 1'b0;
    ingest_base_addr     = '0;
    ingest_req_len       = '0;
    manage_prep_req_val  = 1'b1;
    manage_prep_req_data = mk(0, 0);
    manage_prep_req_last = 1'b0;
    log_wr_rdy           = 1'b1;
    repeat (3) tick();

    // Reset state, with a beat sitting on the bus.
    chk("rst_wr_val", DW'(log_wr_val), DW'(0));
    chk("rst_rdy", DW'(prep_manage_req_rdy), DW'(0));
    chk("rst_done", DW'(log_write_done), DW'(0));
    chk("rst_err", DW'(ingest_len_err), DW'(0));
    chk("rst_busy", DW'(ingest_busy), DW'(0));
    chk("rst_addr", DW'(log_wr_addr), DW'(0));
    chk("rst_data", log_wr_data, '0);
    rst = 1'b0;
    manage_prep_req_val = 1'b0;
    tick();
    chk("idle_rdy", DW'(prep_manage_req_rdy), DW'(0));

    // 64 bytes at base 5: single beat, minimum latency.
    w0 = wa_q.size();
    start(12'd5, 16'd64);
    chk("t1_busy", DW'(ingest_busy), DW'(1));
    chk("t1_done_c1", DW'(log_write_done), DW'(0));
    manage_prep_req_val  = 1'b1;
    manage_prep_req_data = mk(1, 0);
    manage_prep_req_last = 1'b1;
    #1;
    chk("t1_wr_val", DW'(log_wr_val), DW'(1));
    chk("t1_wr_addr", DW'(log_wr_addr), DW'(5));
    chk("t1_wr_data", log_wr_data, mk(1, 0));
    chk("t1_rdy", DW'(prep_manage_req_rdy), DW'(1));
    @(posedge clk); #1;
    manage_prep_req_val  = 1'b0;
    manage_prep_req_last = 1'b0;
    chk("t1_done_c2", DW'(log_write_done), DW'(1));
    chk("t1_err", DW'(ingest_len_err), DW'(0));
    chk("t1_busy_end", DW'(ingest_busy), DW'(0));
    chk("t1_nwr", DW'(wa_q.size() - w0), DW'(1));
    chk("t1_addr_log", DW'(wa_q[w0]), DW'(5));

    // 200 bytes at 4094 -> 4 words wrapping; stray start mid-request ignored.
    exp_a2 = '{12'd4094, 12'd4095, 12'd0, 12'd1};
    w0 = wa_q.size();
    start(12'd4094, 16'd200);
    chk("t2_done_clr", DW'(log_write_done), DW'(0));
    beat(mk(2, 0), 1'b0, "t2_b0");
    start_req_ingest = 1'b1;
    ingest_base_addr = 12'd100;
    ingest_req_len   = 16'd64;
    beat(mk(2, 1), 1'b0, "t2_b1");
    start_req_ingest = 1'b0;
    beat(mk(2, 2), 1'b0, "t2_b2");
    chk("t2_done_early", DW'(log_write_done), DW'(0));
    beat(mk(2, 3), 1'b1, "t2_b3");
    chk("t2_done", DW'(log_write_done), DW'(1));
    chk("t2_err", DW'(ingest_len_err), DW'(0));
    chk("t2_nwr", DW'(wa_q.size() - w0), DW'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_addr%0d", i), DW'(wa_q[w0 + i]), DW'(exp_a2[i]));
      chk($sformatf("t2_data%0d", i), wd_q[w0 + i], mk(2, i));
    end

    // Start in DONE clears done next cycle; 128 bytes with log_wr_rdy toggling.
    w0 = wa_q.size();
    start(12'd10, 16'd128);
    chk("t3_done_clr", DW'(log_write_done), DW'(0));
    chk("t3_busy", DW'(ingest_busy), DW'(1));
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
      manage_prep_req_val  = 1'b1;
      manage_prep_req_data = mk(3, k);
      manage_prep_req_last = (k == 1);
      log_wr_rdy           = (cyc % 2 == 1);
      #1;
      chk("t3_rdy_mirror", DW'(prep_manage_req_rdy), DW'(log_wr_rdy));
      xf = log_wr_rdy;
      @(posedge clk); #1;
      if (xf) k++;
    end
    manage_prep_req_val  = 1'b0;
    manage_prep_req_last = 1'b0;
    log_wr_rdy           = 1'b1;
    chk("t3_beats", DW'(k), DW'(2));
    chk("t3_nwr", DW'(wa_q.size() - w0), DW'(2));
    chk("t3_addr0", DW'(wa_q[w0]), DW'(10));
    chk("t3_addr1", DW'(wa_q[w0 + 1]), DW'(11));
    chk("t3_data0", wd_q[w0], mk(3, 0));
    chk("t3_data1", wd_q[w0 + 1], mk(3, 1));
    chk("t3_done", DW'(log_write_done), DW'(1));

    // 64 bytes but 3 beats: one write, two drained, length error.
    w0 = wa_q.size();
    d0 = n_drain;
    start(12'd20, 16'd64);
    beat(mk(4, 0), 1'b0, "t4_b0");
    chk("t4_err_mid", DW'(ingest_len_err), DW'(1));
    beat(mk(4, 1), 1'b0, "t4_b1");
    chk("t4_done_early", DW'(log_write_done), DW'(0));
    beat(mk(4, 2), 1'b1, "t4_b2");
    chk("t4_done", DW'(log_write_done), DW'(1));
    chk("t4_err", DW'(ingest_len_err), DW'(1));
    chk("t4_nwr", DW'(wa_q.size() - w0), DW'(1));
    chk("t4_addr", DW'(wa_q[w0]), DW'(20));
    chk("t4_drained", DW'(n_drain - d0), DW'(2));

    // 192 bytes but last on beat 2: short write kept, error, done at once.
    w0 = wa_q.size();
    start(12'd30, 16'd192);
    chk("t5_err_clr", DW'(ingest_len_err), DW'(0));
    beat(mk(5, 0), 1'b0, "t5_b0");
    beat(mk(5, 1), 1'b1, "t5_b1");
    chk("t5_done", DW'(log_write_done), DW'(1));
    chk("t5_err", DW'(ingest_len_err), DW'(1));
    chk("t5_busy", DW'(ingest_busy), DW'(0));
    chk("t5_nwr", DW'(wa_q.size() - w0), DW'(2));
    chk("t5_addr1", DW'(wa_q[w0 + 1]), DW'(31));
    chk("t5_data1", wd_q[w0 + 1], mk(5, 1));

    // Zero length: straight to DONE, stray beat left on the bus.
    w0 = wa_q.size();
    start(12'd40, 16'd0);
    manage_prep_req_val  = 1'b1;
    manage_prep_req_data = mk(6, 0);
    #1;
    chk("t6_done", DW'(log_write_done), DW'(1));
    chk("t6_err", DW'(ingest_len_err), DW'(0));
    chk("t6_busy", DW'(ingest_busy), DW'(0));
    chk("t6_rdy", DW'(prep_manage_req_rdy), DW'(0));
    chk("t6_wr_val", DW'(log_wr_val), DW'(0));
    tick();
    manage_prep_req_val = 1'b0;
    chk("t6_nwr", DW'(wa_q.size() - w0), DW'(0));

    // Reset mid-INGEST: partial write stays, everything back to 0.
    w0 = wa_q.size();
    start(12'd50, 16'd256);
    beat(mk(7, 0), 1'b0, "t7_b0");
    manage_prep_req_val  = 1'b1;
    manage_prep_req_data = mk(7, 1);
    rst = 1'b1;
    tick();
    chk("t7_wr_val", DW'(log_wr_val), DW'(0));
    chk("t7_rdy", DW'(prep_manage_req_rdy), DW'(0));
    chk("t7_done", DW'(log_write_done), DW'(0));
    chk("t7_err", DW'(ingest_len_err), DW'(0));
    chk("t7_busy", DW'(ingest_busy), DW'(0));
    chk("t7_addr", DW'(log_wr_addr), DW'(0));
    chk("t7_data", log_wr_data, '0);
    rst = 1'b0;
    manage_prep_req_val = 1'b0;
    tick();
    chk("t7_nwr", DW'(wa_q.size() - w0), DW'(1));
    chk("t7_addr_log", DW'(wa_q[w0]), DW'(50));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
